muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine and its sequencing FSM, sitting beside the EXE-stage ALU.
- Accepts one operation from EXE, raises a stall request to the hazard unit while computing, then presents the result for one consume cycle.
- EXE muxes `result_o` into its aluout path when `done_o` is high.

---
 rtl/CPU_def.sv | 26 ++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_iter_core.sv | 61 ++++++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/CPU_def.sv
// Shared CPU definitions: M-extension func3 encodings, muldiv FSM state type, data width.
package CPU_def;

   localparam int DATA_BITS = 32;

   localparam logic [2:0] MUL_F3    = 3'b000;
   localparam logic [2:0] MULH_F3   = 3'b001;
   localparam logic [2:0] MULHSU_F3 = 3'b010;
   localparam logic [2:0] MULHU_F3  = 3'b011;
   localparam logic [2:0] DIV_F3    = 3'b100;
   localparam logic [2:0] DIVU_F3   = 3'b101;
   localparam logic [2:0] REM_F3    = 3'b110;
   localparam logic [2:0] REMU_F3   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EXE-stage <-> muldiv_unit handshake bundle; master is the EXE stage, slave is the unit.
interface muldiv_unit_if #(
   parameter int DATA_BITS = 32
);
   logic                 start_i;
   logic [2:0]           func3_i;
   logic [DATA_BITS-1:0] rs1_i;
   logic [DATA_BITS-1:0] rs2_i;
   logic                 flush_i;
   logic                 cpuwait_i;
   logic                 stall_req_o;
   logic                 busy_o;
   logic                 done_o;
   logic [DATA_BITS-1:0] result_o;

   modport master (
      output start_i, func3_i, rs1_i, rs2_i, flush_i, cpuwait_i,
      input  stall_req_o, busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, func3_i, rs1_i, rs2_i, flush_i, cpuwait_i,
      output stall_req_o, busy_o, done_o, result_o
   );
endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiply of magnitudes, restoring shift-subtract divide.
module muldiv_iter_core #(
   parameter int DATA_BITS = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   step,
   input  logic                   is_div,
   input  logic [DATA_BITS-1:0]   opa,
   input  logic [DATA_BITS-1:0]   opb,
   output logic [2*DATA_BITS-1:0] product,
   output logic [DATA_BITS-1:0]   quotient,
   output logic [DATA_BITS-1:0]   remainder
);

   // hi_reg: product high word / partial remainder; lo_reg: multiplier bits / quotient bits
   logic [DATA_BITS-1:0] hi_reg, lo_reg, opb_reg;
   logic [DATA_BITS-1:0] hi_next, lo_next;
   logic [DATA_BITS:0]   add_sum;
   logic [DATA_BITS:0]   part_rem;

   always_comb begin
      add_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
      part_rem = {hi_reg, lo_reg[DATA_BITS-1]};
      hi_next  = hi_reg;
      lo_next  = lo_reg;
      if (is_div) begin
         if (part_rem >= {1'b0, opb_reg}) begin
            hi_next = DATA_BITS'(part_rem - {1'b0, opb_reg});
            lo_next = {lo_reg[DATA_BITS-2:0], 1'b1};
         end else begin
            hi_next = part_rem[DATA_BITS-1:0];
            lo_next = {lo_reg[DATA_BITS-2:0], 1'b0};
         end
      end else begin
         hi_next = add_sum[DATA_BITS:1];
         lo_next = {add_sum[0], lo_reg[DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_reg  <= '0;
         lo_reg  <= '0;
         opb_reg <= '0;
      end else if (load) begin
         hi_reg  <= '0;
         lo_reg  <= opa;
         opb_reg <= opb;
      end else if (step) begin
         hi_reg  <= hi_next;
         lo_reg  <= lo_next;
      end
   end

   assign product   = {hi_reg, lo_reg};
   assign quotient  = lo_reg;
   assign remainder = hi_reg;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide sequencer beside the EXE ALU; stalls the pipe while iterating.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module muldiv_unit #(
   parameter int DATA_BITS = CPU_def::DATA_BITS,
   parameter int CNT_BITS  = 5
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_unit_if.slave   bus
);
   import CPU_def::*;

   localparam logic [DATA_BITS-1:0] MIN_VAL  = {1'b1, {(DATA_BITS-1){1'b0}}};
   localparam logic [DATA_BITS-1:0] ONES     = '1;
   localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(DATA_BITS-1);

   muldiv_state_e          state_reg, state_next;
   logic [CNT_BITS-1:0]    cnt_reg;
   logic [2:0]             func3_reg;
   logic                   neg_reg;
   logic [DATA_BITS-1:0]   result_reg;

   logic                   a_signed, b_signed, sign_a, sign_b, neg_in;
   logic [DATA_BITS-1:0]   mag_a, mag_b;
   logic                   div_zero, div_ovf, fast_hit;
   logic [DATA_BITS-1:0]   fast_result;
   logic                   accept, core_load, core_step, stall_req;

   logic [2*DATA_BITS-1:0] product, prod_fixed;
   logic [DATA_BITS-1:0]   quotient, remainder, div_val, fix_result;

   // Operand conditioning: magnitudes plus the sign the final result must carry
   always_comb begin
      a_signed = !(bus.func3_i == MULHU_F3 || bus.func3_i == DIVU_F3 ||
                   bus.func3_i == REMU_F3);
      b_signed = a_signed && (bus.func3_i != MULHSU_F3);
      sign_a   = a_signed & bus.rs1_i[DATA_BITS-1];
      sign_b   = b_signed & bus.rs2_i[DATA_BITS-1];
      mag_a    = sign_a ? -bus.rs1_i : bus.rs1_i;
      mag_b    = sign_b ? -bus.rs2_i : bus.rs2_i;
      neg_in   = (bus.func3_i == REM_F3) ? sign_a : (sign_a ^ sign_b);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [DATA_BITS:0]     fm_a, fm_b;
   logic signed [2*DATA_BITS+1:0] fm_prod;

   always_comb begin
      fm_a    = {a_signed & bus.rs1_i[DATA_BITS-1], bus.rs1_i};
      fm_b    = {b_signed & bus.rs2_i[DATA_BITS-1], bus.rs2_i};
      fm_prod = fm_a * fm_b;
   end
`endif

   // Results that never need the iterative core
   always_comb begin
      div_zero    = is_div_op(bus.func3_i) && (bus.rs2_i == '0);
      div_ovf     = (bus.func3_i == DIV_F3 || bus.func3_i == REM_F3) &&
                    (bus.rs1_i == MIN_VAL) && (bus.rs2_i == ONES);
      fast_hit    = div_zero || div_ovf;
      fast_result = '0;
      if (div_zero)
         fast_result = bus.func3_i[1] ? bus.rs1_i : ONES;
      else if (div_ovf)
         fast_result = bus.func3_i[1] ? '0 : MIN_VAL;
`ifdef MULDIV_FAST_MUL_EN
      if (!is_div_op(bus.func3_i)) begin
         fast_hit    = 1'b1;
         fast_result = (bus.func3_i == MUL_F3) ? fm_prod[DATA_BITS-1:0]
                                               : fm_prod[2*DATA_BITS-1:DATA_BITS];
      end
`endif
   end

   assign accept = (state_reg == MD_IDLE) && bus.start_i && !bus.flush_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= MD_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      core_load  = 1'b0;
      core_step  = 1'b0;
      stall_req  = 1'b0;
      case (state_reg)
         MD_IDLE: begin
            if (accept) begin
               if (fast_hit) begin
                  state_next = MD_DONE;
               end else begin
                  state_next = MD_CALC;
                  core_load  = 1'b1;
                  stall_req  = 1'b1;
               end
            end
         end
         MD_CALC: begin
            stall_req = 1'b1;
            core_step = 1'b1;
            if (cnt_reg == CNT_LAST) state_next = MD_FIX;
         end
         MD_FIX: begin
            stall_req  = 1'b1;
            state_next = MD_DONE;
         end
         MD_DONE: begin
            if (!bus.cpuwait_i) state_next = MD_IDLE;
         end
         default: state_next = MD_IDLE;
      endcase
      if (bus.flush_i) state_next = MD_IDLE;
   end

   muldiv_iter_core #(.DATA_BITS(DATA_BITS)) u_core (
      .clk       (clk),
      .rst       (rst),
      .load      (core_load),
      .step      (core_step),
      .is_div    (is_div_op(func3_reg)),
      .opa       (mag_a),
      .opb       (mag_b),
      .product   (product),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Sign correction and word select applied once the magnitudes are final
   always_comb begin
      prod_fixed = neg_reg ? -product : product;
      div_val    = func3_reg[1] ? remainder : quotient;
      fix_result = neg_reg ? -div_val : div_val;
      if (!is_div_op(func3_reg))
         fix_result = (func3_reg == MUL_F3) ? prod_fixed[DATA_BITS-1:0]
                                            : prod_fixed[2*DATA_BITS-1:DATA_BITS];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         func3_reg  <= '0;
         neg_reg    <= 1'b0;
         result_reg <= '0;
      end else begin
         if (core_load) begin
            cnt_reg   <= '0;
            func3_reg <= bus.func3_i;
            neg_reg   <= neg_in;
         end else if (core_step) begin
            cnt_reg   <= cnt_reg + 1'b1;
         end
         if (accept && fast_hit)
            result_reg <= fast_result;
         else if (state_reg == MD_FIX && !bus.flush_i)
            result_reg <= fix_result;
      end
   end

   assign bus.stall_req_o = stall_req;
   assign bus.busy_o      = (state_reg == MD_CALC) || (state_reg == MD_FIX);
   assign bus.done_o      = (state_reg == MD_DONE);
   assign bus.result_o    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops against an arithmetic reference.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.DATA_BITS(32)) bus ();

   muldiv_unit #(.DATA_BITS(32), .CNT_BITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference: RV32M semantics computed with wide plain arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s, p;
      logic [63:0] up;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ub_s = {32'h0, b};
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub_s; return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return 34;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Drive at posedge+1, sample at posedge+2; cycle 0 is the start cycle
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
      int lat, cyc, stall_cnt, busy_cnt;
      logic [31:0] got;
      lat = ref_latency(f3, a, b);
      @(posedge clk); #1;
      bus.cpuwait_i = (hold > 0);
      bus.start_i = 1'b1; bus.func3_i = f3; bus.rs1_i = a; bus.rs2_i = b;
      #1;
      stall_cnt = bus.stall_req_o ? 1 : 0;
      busy_cnt  = 0;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.rs1_i = $urandom; bus.rs2_i = $urandom;
      #1;
      cyc = 1;
      while (!bus.done_o && cyc < 100) begin
         if (bus.stall_req_o) stall_cnt++;
         if (bus.busy_o) busy_cnt++;
         @(posedge clk); #2;
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      check({tag, " result"}, bus.result_o, exp);
      check({tag, " stall cycles"}, 32'(stall_cnt), 32'((lat == 1) ? 0 : lat));
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'((lat == 1) ? 0 : lat - 1));
      check({tag, " stall low on done"}, 32'(bus.stall_req_o), 32'd0);
      got = exp;
      if (hold > 0) begin
         for (int i = 1; i < hold; i++) begin
            @(posedge clk); #2;
            check({tag, " held done"}, 32'(bus.done_o), 32'd1);
            check({tag, " held result"}, bus.result_o, got);
         end
         @(posedge clk); #1;
         bus.cpuwait_i = 1'b0;
         #1;
         check({tag, " done until release"}, 32'(bus.done_o), 32'd1);
      end
      @(posedge clk); #2;
      check({tag, " done drops"}, 32'(bus.done_o), 32'd0);
      check({tag, " result holds in idle"}, bus.result_o, got);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          done_seen;
      bus.start_i = 1'b0; bus.func3_i = 3'd0; bus.rs1_i = '0; bus.rs2_i = '0;
      bus.flush_i = 1'b0; bus.cpuwait_i = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      check("reset stall_req", 32'(bus.stall_req_o), 32'd0);
      check("reset busy", 32'(bus.busy_o), 32'd0);
      check("reset done", 32'(bus.done_o), 32'd0);
      check("reset result", bus.result_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
      run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
      run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 0);
      run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 32'd5, 0);
      run_op("DIV min/-1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("REM min/-1", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
      run_op("MULHU cpuwait", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 4);

      // start together with flush in IDLE must not launch
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.func3_i = 3'd5; bus.rs1_i = 32'd50; bus.rs2_i = 32'd3;
      #1;
      check("flush+start stall", 32'(bus.stall_req_o), 32'd0);
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      #1;
      check("flush+start busy", 32'(bus.busy_o), 32'd0);
      check("flush+start done", 32'(bus.done_o), 32'd0);

      // abort in the middle of CALC
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.func3_i = 3'd5; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd7;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      #1;
      check("pre-flush busy", 32'(bus.busy_o), 32'd1);
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      #1;
      check("flush busy", 32'(bus.busy_o), 32'd0);
      check("flush done", 32'(bus.done_o), 32'd0);
      check("flush stall", 32'(bus.stall_req_o), 32'd0);
      run_op("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 32'd3, 0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (bus.done_o) done_seen++;
      end
      check("no stale done after flush", 32'(done_seen), 32'd0);

      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op($sformatf("rand%0d f3=%0d a=%h b=%h", n, f3, a, b), f3, a, b,
                ref_result(f3, a, b), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
